wb_arb_conbus: RTL and testbench

WB_ARB_CONBUS -- requirements
Module: wb_arb_conbus

---
 rtl/wb_arb_conbus.sv | 172 +++++++++++++++++
 tb/tb_wb_arb_conbus.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_conbus.sv
// rtl/wb_arb_conbus.sv - Wishbone shared-bus interconnect: round-robin arbiter, address decoder, watchdog
module wb_arb_conbus #(
    parameter int                  NM      = 2,
    parameter int                  NS      = 6,
    parameter int                  DEC_W   = 3,
    parameter logic [NS*DEC_W-1:0] S_ADDR  = {3'b110, 3'b101, 3'b100, 3'b010, 3'b011, 3'b000},
    parameter int                  TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic [NM-1:0]    grant_o
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t          state_q;
    logic [NM-1:0]   grant_q;
    logic [IW-1:0]   last_q;
    logic [NM-1:0]   req_q;
    logic            err_q, err_d;
    logic [15:0]     wd_q, wd_d;

    logic            own, own_cyc, own_stb;
    logic            sel_hit, dec_ack;
    logic [SW-1:0]   sel_idx;
    logic            pick_ok;
    logic [IW-1:0]   pick_idx;

    assign own     = (state_q == ST_OWN);
    assign grant_o = grant_q;

    // During ownership last_q is the current owner's index.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (own && last_q == IW'(k)) begin
                own_cyc = m_cyc_i[k];
                own_stb = m_stb_i[k];
                s_adr_o = m_adr_i[32*k +: 32];
                s_dat_o = m_dat_i[32*k +: 32];
                s_sel_o = m_sel_i[4*k +: 4];
                s_we_o  = m_we_i[k];
            end
        end
    end

    // Descending scan so the lowest matching slave wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int j = NS - 1; j >= 0; j--) begin
            if (own && s_adr_o[31 -: DEC_W] == S_ADDR[DEC_W*j +: DEC_W]) begin
                sel_hit = 1'b1;
                sel_idx = SW'(j);
            end
        end
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        dec_ack = 1'b0;
        m_dat_o = '0;
        for (int j = 0; j < NS; j++) begin
            if (sel_hit && sel_idx == SW'(j)) begin
                s_cyc_o[j] = own_cyc;
                s_stb_o[j] = own_stb & ~err_q;
                dec_ack    = s_ack_i[j];
                m_dat_o    = s_dat_i[32*j +: 32];
            end
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int k = 0; k < NM; k++) begin
            if (own && last_q == IW'(k)) begin
                m_ack_o[k] = dec_ack & ~err_q;
                m_err_o[k] = err_q;
            end
        end
    end

    // Round-robin search starting one past the last owner.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NM; i++) begin
            for (int k = 0; k < NM; k++) begin
                if (!pick_ok && k == (int'(last_q) + 1 + i) % NM && req_q[k] && m_cyc_i[k]) begin
                    pick_ok  = 1'b1;
                    pick_idx = IW'(k);
                end
            end
        end
    end

    always_comb begin
        err_d = 1'b0;
        wd_d  = '0;
        if (own_cyc && own_stb && !err_q) begin
            if (!sel_hit) begin
                err_d = 1'b1;
            end else if (!dec_ack && TIMEOUT != 0) begin
                if (wd_q + 16'd1 == 16'(TIMEOUT)) begin
                    err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
            req_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            req_q <= m_cyc_i;
            err_q <= err_d;
            wd_q  <= wd_d;
            case (state_q)
                ST_IDLE: begin
                    if (pick_ok) begin
                        state_q <= ST_OWN;
                        grant_q <= NM'(1) << pick_idx;
                        last_q  <= pick_idx;
                    end
                end
                ST_OWN: begin
                    if (!own_cyc) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arb_conbus.sv
// tb/tb_wb_arb_conbus.sv - directed scoreboard bench for wb_arb_conbus
module tb_wb_arb_conbus;
    localparam int NM = 2;
    localparam int NS = 6;
    localparam int DEC_W = 3;
    localparam int TIMEOUT = 4;
    // Slave 5 duplicates slave 1's match value so the lowest-index rule is exercised.
    localparam logic [NS*DEC_W-1:0] S_ADDR = {3'b001, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NM*32-1:0] m_adr_i = '0;
    logic [NM*32-1:0] m_dat_i = '0;
    logic [NM*4-1:0]  m_sel_i = '0;
    logic [NM-1:0]    m_we_i = '0;
    logic [NM-1:0]    m_cyc_i = '0;
    logic [NM-1:0]    m_stb_i = '0;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat_i = '0;
    logic [NS-1:0]    s_ack_i = '0;
    logic [NM-1:0]    grant_o;

    always #5 clk = ~clk;

    wb_arb_conbus #(.NM(NM), .NS(NS), .DEC_W(DEC_W), .S_ADDR(S_ADDR), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        assert (sb.size() > 0) else $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    logic [1:0]  g_tab [10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [9:0]  wd_stb = 10'b0111101111;
    int          cnt [2];

    initial begin
        for (int j = 0; j < NS; j++) s_dat_i[32*j +: 32] = 32'h1111_1111 * (j + 1);
        s_dat_i[32*1 +: 32] = 32'hCAFE_F00D;

        // Reset held while master 0 already requests slave 1.
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        m_adr_i[31:0] = 32'h2000_0010;
        repeat (2) @(negedge clk);
        #1;
        expect_val("rst_grant", 0);  check(32'(grant_o));
        expect_val("rst_s_stb", 0);  check(32'(s_stb_o));
        expect_val("rst_s_adr", 0);  check(s_adr_o);
        expect_val("rst_m_dat", 0);  check(m_dat_o);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        expect_val("first_edge_no_grant", 0); check(32'(grant_o));
        @(negedge clk); #1;
        expect_val("rd_grant", 32'b01);      check(32'(grant_o));
        expect_val("rd_s_stb", 32'b000010);  check(32'(s_stb_o));
        expect_val("rd_s_adr", 32'h2000_0010); check(s_adr_o);
        expect_val("rd_ack_wait", 0);        check(32'(m_ack_o));
        @(negedge clk);
        s_ack_i = 6'b000010;
        #1;
        expect_val("rd_ack", 32'b01);        check(32'(m_ack_o));
        expect_val("rd_dat", 32'hCAFE_F00D); check(m_dat_o);
        expect_val("rd_err", 0);             check(32'(m_err_o));
        @(negedge clk);
        m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = '0;
        #1;
        expect_val("rd_stb_drop", 0);        check(32'(s_stb_o));
        @(negedge clk); #1;
        expect_val("rd_idle", 0);            check(32'(grant_o));

        // Both masters request from reset, each holding ownership for three cycles.
        m_adr_i = '0;
        @(negedge clk); rst = 1'b0; m_cyc_i = 2'b11;
        @(negedge clk); rst = 1'b1;
        cnt[0] = 0; cnt[1] = 0;
        for (int i = 0; i < 10; i++) expect_val("rr_grant", 32'(g_tab[i]));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check(32'(grant_o));
            for (int k = 0; k < 2; k++) begin
                if (grant_o[k]) begin
                    cnt[k]++;
                    if (cnt[k] == 3) begin
                        m_cyc_i[k] = 1'b0;
                        cnt[k] = 0;
                    end
                end else if (!m_cyc_i[k]) begin
                    m_cyc_i[k] = 1'b1;
                end
            end
        end
        m_cyc_i = 2'b00;
        repeat (2) @(negedge clk);

        // Master 1 to an unmapped address.
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_adr_i[63:32] = 32'hE000_0000;
        repeat (2) @(negedge clk);
        #1;
        expect_val("nm_grant", 32'b10);  check(32'(grant_o));
        expect_val("nm_err_pre", 0);     check(32'(m_err_o));
        @(negedge clk); #1;
        expect_val("nm_err", 32'b10);    check(32'(m_err_o));
        expect_val("nm_ack", 0);         check(32'(m_ack_o));
        expect_val("nm_s_stb", 0);       check(32'(s_stb_o));
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        @(negedge clk); #1;
        expect_val("nm_err_clear", 0);   check(32'(m_err_o));
        @(negedge clk);

        // Slave 2 never acknowledges: watchdog fires every fifth cycle.
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'h4000_0000;
        for (int i = 0; i < 10; i++) begin
            expect_val("wd_stb", wd_stb[i] ? 32'b000100 : 32'b0);
            expect_val("wd_err", wd_stb[i] ? 32'b0 : 32'b01);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check(32'(s_stb_o));
            check(32'(m_err_o));
        end
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        repeat (2) @(negedge clk);

        // Reset mid-transfer on slave 0, then master 0 must win again.
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'h0000_0ABC;
        s_ack_i = 6'b000001; s_dat_i[31:0] = 32'h5A5A_5A5A;
        repeat (2) @(negedge clk);
        #1;
        expect_val("mid_s_stb", 32'b000001);    check(32'(s_stb_o));
        expect_val("mid_ack", 32'b01);          check(32'(m_ack_o));
        expect_val("mid_dat", 32'h5A5A_5A5A);   check(m_dat_o);
        m_cyc_i = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_val("rst_mid_grant", 0);  check(32'(grant_o));
        expect_val("rst_mid_s_cyc", 0);  check(32'(s_cyc_o));
        expect_val("rst_mid_ack", 0);    check(32'(m_ack_o));
        expect_val("rst_mid_s_adr", 0);  check(s_adr_o);
        expect_val("rst_mid_m_dat", 0);  check(m_dat_o);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        expect_val("rel_no_grant", 0);   check(32'(grant_o));
        @(negedge clk); #1;
        expect_val("rel_m0_first", 32'b01); check(32'(grant_o));

        // Owner keeps the bus locked while master 1 waits.
        m_stb_i = 2'b00; s_ack_i = '0;
        for (int i = 0; i < 20; i++) expect_val("lock_grant", 32'b01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check(32'(grant_o));
        end
        m_cyc_i = 2'b10;
        expect_val("lock_idle", 0);
        expect_val("lock_m1", 32'b10);
        @(negedge clk); #1;
        check(32'(grant_o));
        @(negedge clk); #1;
        check(32'(grant_o));

        m_cyc_i = 2'b00;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
